scan_sel_gen: RTL and testbench

SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

---
 rtl/scan_pkg.sv | 13 +
 rtl/next_chan_find.sv | 25 ++
 rtl/scan_sel_gen.sv | 91 +++++++++
 tb/tb_scan_sel_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and sizes for the scan select generator.
// Four channels addressed by a 2-bit index; the FSM has two states.
package scan_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/next_chan_find.sv
// Combinational search for the next enabled channel, ascending and modulo NCH; zero latency.
// No flow control; returns sel unchanged when no channel is enabled.
module next_chan_find
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic [NCH-1:0]   mask,
  input  logic             incl,
  output logic [SEL_W-1:0] target
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the closest enabled channel wins.
  // Exclusive search spans offsets 1..NCH, so a lone enabled channel finds itself.
  always_comb begin
    target = sel;
    idx    = sel;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = sel + SEL_W'(k) + SEL_W'(!incl);
      if (mask[idx]) target = idx;
    end
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Channel-select scanner: prescaler-paced or single-stepped; outputs one cycle after the deciding edge.
// No backpressure; en=0 or an empty mask returns to IDLE on the next edge.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [NCH-1:0]   mask,
  output logic [SEL_W-1:0] sel,
  output logic             sel_vld,
  output logic             tick,
  output logic             wrap
);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic             mode_q;
  logic             run_ok;
  logic             mode_chg;
  logic             advance;
  logic [SEL_W-1:0] target;

  assign run_ok   = en && (|mask);
  assign mode_chg = (mode != mode_q);

  // A mode switch only clears the prescaler; the advance resumes from the new mode next cycle.
  always_comb begin
    advance = 1'b0;
    if (!mode_chg) advance = mode ? step : (cnt >= div);
  end

  // Inclusive search when entering RUN, exclusive search for every advance.
  next_chan_find u_find (
    .sel    (sel),
    .mask   (mask),
    .incl   (state == IDLE),
    .target (target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      mode_q  <= 1'b0;
      sel_vld <= 1'b0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      mode_q <= mode;
      tick   <= 1'b0;
      wrap   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (run_ok) begin
            state   <= RUN;
            sel     <= target;
            sel_vld <= 1'b1;
          end else begin
            sel_vld <= 1'b0;
          end
        end
        RUN: begin
          if (!run_ok) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_vld <= 1'b0;
          end else begin
            sel_vld <= 1'b1;
            if (mode_chg || mode || (cnt >= div)) cnt <= '0;
            else                                   cnt <= cnt + DIV_W'(1);
            if (advance) begin
              sel  <= target;
              tick <= 1'b1;
              wrap <= (target <= sel);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: directed scenarios plus random traffic against a cycle reference model.
module tb_scan_sel_gen;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             mode;
  logic             step;
  logic [DIV_W-1:0] div;
  logic [3:0]       mask;
  logic [1:0]       sel;
  logic             sel_vld;
  logic             tick;
  logic             wrap;

  always #5 clk = ~clk;

  scan_sel_gen #(.DIV_W(DIV_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .step    (step),
    .div     (div),
    .mask    (mask),
    .sel     (sel),
    .sel_vld (sel_vld),
    .tick    (tick),
    .wrap    (wrap)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit m_run;
  int m_sel, m_cnt, m_pmode;
  bit m_vld, m_tick, m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_chan(int s, logic [3:0] m, bit incl);
    int first = incl ? 0 : 1;
    for (int off = first; off < first + 4; off++)
      if (m[(s + off) % 4]) return (s + off) % 4;
    return s;
  endfunction

  task automatic model_reset();
    m_run = 0; m_sel = 0; m_cnt = 0; m_pmode = 0;
    m_vld = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    bit adv;
    int t;
    if (rst) begin
      model_reset();
      return;
    end
    adv = 0; m_tick = 0; m_wrap = 0;
    if (!m_run) begin
      m_cnt = 0;
      if (en && mask != 0) begin
        m_run = 1; m_vld = 1;
        m_sel = find_chan(m_sel, mask, 1);
      end else begin
        m_vld = 0;
      end
    end else if (!en || mask == 0) begin
      m_run = 0; m_vld = 0; m_cnt = 0;
    end else begin
      if (int'(mode) != m_pmode) m_cnt = 0;
      else if (mode == 0) begin
        if (m_cnt >= int'(div)) begin m_cnt = 0; adv = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        m_cnt = 0; adv = step;
      end
      if (adv) begin
        t = find_chan(m_sel, mask, 0);
        m_wrap = (t <= m_sel);
        m_tick = 1;
        m_sel = t;
      end
    end
    m_pmode = mode;
  endtask

  task automatic compare();
    chk("sel", sel, m_sel);
    chk("sel_vld", sel_vld, m_vld);
    chk("tick", tick, m_tick);
    chk("wrap", wrap, m_wrap);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic rst_pulse();
    rst = 1'b1; en = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int ticks;
    bit found;
    rst = 1'b1; en = 1'b0; mode = 1'b0; step = 1'b0; div = '0; mask = '0;
    model_reset();
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_vld", sel_vld, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    @(negedge clk);
    rst = 1'b0;

    // Auto scan over all channels, period 3
    en = 1; mode = 0; mask = 4'b1111; div = 2;
    repeat (20) cyc();

    // Sparse mask at full speed
    mask = 4'b1010; div = 0;
    repeat (10) cyc();

    // Single-step with pulses in cycles 5 and 9
    rst_pulse();
    en = 1; mode = 1; mask = 4'b1111; step = 0;
    cyc();
    ticks = 0;
    for (int i = 2; i <= 12; i++) begin
      step = (i == 5 || i == 9);
      cyc();
      if (tick === 1'b1) ticks++;
    end
    step = 0;
    chk("step_sel", sel, 2);
    chk("step_ticks", ticks, 2);

    // Empty mask holds IDLE, then a single channel
    mode = 0; mask = 4'b0000; div = 3;
    repeat (4) cyc();
    mask = 4'b0100;
    cyc();
    chk("one_ch_sel", sel, 2);
    chk("one_ch_vld", sel_vld, 1);
    repeat (12) cyc();

    // Shrinking div below cnt advances on the next edge
    mask = 4'b1111; div = 10;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (m_run && m_cnt == 7) found = 1;
    end
    chk("cnt7_reached", found, 1);
    div = 2;
    cyc();
    chk("div_drop_tick", tick, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (m_sel == 3) found = 1;
    end
    chk("sel3_reached", found, 1);
    // Asynchronous reset mid-cycle, observed before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_vld", sel_vld, 0);
    chk("arst_tick", tick, 0);
    cyc();
    rst = 1'b0;

    // Random traffic
    en = 1; mode = 0; mask = 4'b1111; div = 1;
    for (int i = 0; i < 1500; i++) begin
      en   = ($urandom_range(0, 15) != 0);
      step = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0)  mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 14) == 0) div = DIV_W'($urandom_range(0, 4));
      rst  = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
